// File: rtl/display_pkg.sv
// Shared types and constants for the GPIO decimal display driver:
// FSM state encoding, BCD accumulator geometry and the 7-segment lookup.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         BCD_DIGITS = 10;
    localparam int         BCD_W      = 4 * BCD_DIGITS;

    // Active-low gfedcba patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Double-dabble correction: every BCD nibble of 5 or more gets +3.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// One decimal digit to an active-low 7-segment pattern; blank or a
// non-decimal nibble produces an unlit display.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_LUT[digit];
        end
    end

endmodule

// File: rtl/gpio_display_driver.sv
// Captures the CPU GPIO display word, converts it to BCD with a serial
// shift-add-3 engine and drives eight active-low HEX displays.
module gpio_display_driver
    import display_pkg::*;
#(
    parameter int BIN_W         = 32,
    parameter int NUM_DIGITS    = 8,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIN_W-1:0]        value,
    input  logic                    load,
    output logic [NUM_DIGITS*7-1:0] hex,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(BIN_W);

    // Handshake: load is a single-cycle strobe with no back-pressure. A load
    // arriving mid-conversion is parked in a one-deep buffer; a newer load
    // overwrites it, and a load at the DONE edge takes priority over it.
    disp_state_t state, state_next;

    logic [BIN_W-1:0]        shreg;
    logic [BCD_W-1:0]        acc;
    logic [BCD_W-1:0]        acc_adj;
    logic [CNT_W-1:0]        cnt;
    logic                    pend_v;
    logic [BIN_W-1:0]        pend_val;

    logic                    start;
    logic                    shifting;
    logic                    capture;
    logic [BIN_W-1:0]        start_val;
    logic                    last_bit;

    logic [NUM_DIGITS-1:0]   blank;
    logic                    ovf_next;
    logic [NUM_DIGITS*7-1:0] seg_next;

    assign acc_adj  = bcd_add3(acc);
    assign last_bit = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load || pend_v) state_next = SHIFT;
            SHIFT:   if (last_bit)       state_next = DONE;
            DONE:    state_next = (load || pend_v) ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shifting  = (state == SHIFT);
        capture   = (state == DONE);
        start     = ((state == IDLE) || (state == DONE)) && (load || pend_v);
        start_val = load ? value : pend_val;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            pend_v   <= 1'b0;
            pend_val <= '0;
        end else begin
            if (start) begin
                shreg <= start_val;
                acc   <= '0;
                cnt   <= '0;
            end else if (shifting) begin
                {acc, shreg} <= {acc_adj, shreg} << 1;
                cnt          <= cnt + 1'b1;
            end
            if (start) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pend_v   <= 1'b1;
                pend_val <= value;
            end
        end
    end

    // Blank from the top down until the first nonzero digit; digit 0 always
    // shows, and nothing blanks when the value spills past the displays.
    always_comb begin
        logic seen_nz;
        ovf_next = 1'b0;
        for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            ovf_next = ovf_next | (acc[4*i +: 4] != 4'd0);
        end
        seen_nz = 1'b0;
        blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz  = seen_nz | (acc[4*i +: 4] != 4'd0);
            blank[i] = (BLANK_LEADING != 0) && !ovf_next && (i != 0) && !seen_nz;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_encode u_enc (
            .digit (acc[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_next[7*g +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex[7*i +: 7] <= (i == 0) ? SEG_LUT[0] : SEG_BLANK;
            end
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                hex      <= seg_next;
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_gpio_display_driver.sv
// Bench for gpio_display_driver: a decimal-arithmetic reference model checked
// every cycle, plus directed scenarios pinned by literal segment values.
module tb_gpio_display_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value = '0;
    logic        load = 1'b0;
    logic [55:0] hex;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_display_driver #(
        .BIN_W         (32),
        .NUM_DIGITS    (8),
        .BLANK_LEADING (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .hex      (hex),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [55:0] model_hex(input logic [31:0] v);
        logic [55:0]     h;
        logic [3:0]      d [8];
        longint unsigned n;
        bit              ov;
        bit              nz;
        n  = 64'(v);
        ov = (n >= 64'd100000000);
        for (int i = 0; i < 8; i++) begin
            d[i] = 4'(n % 10);
            n    = n / 10;
        end
        nz = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            nz = nz | (d[i] != 4'd0);
            h[i*7 +: 7] = (!ov && i > 0 && !nz) ? 7'h7F : seg_tab[d[i]];
        end
        return h;
    endfunction

    // Reference model: a conversion completes 33 edges after it starts.
    logic [55:0] m_hex  = {{7{7'h7F}}, 7'h40};
    logic        m_ovf  = 1'b0;
    logic        m_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_pv   = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_cur  = '0;
    logic [31:0] m_pval = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_hex  = {{7{7'h7F}}, 7'h40};
            m_ovf  = 1'b0;
            m_done = 1'b0;
            m_busy = 1'b0;
            m_pv   = 1'b0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 33) begin
                    m_hex  = model_hex(m_cur);
                    m_ovf  = (m_cur >= 32'd100000000);
                    m_done = 1'b1;
                    if (load) begin
                        m_cur = value; m_cnt = 0; m_pv = 1'b0;
                    end else if (m_pv) begin
                        m_cur = m_pval; m_cnt = 0; m_pv = 1'b0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end else if (load) begin
                    m_pv   = 1'b1;
                    m_pval = value;
                end
            end else if (load) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_cur  = value;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_hex", 64'(hex), 64'(m_hex));
        chk("model_busy", 64'(busy), 64'(m_busy));
        chk("model_done", 64'(done), 64'(m_done));
        chk("model_ovf", 64'(overflow), 64'(m_ovf));
    end

    function automatic logic [6:0] dig(input int i);
        return hex[i*7 +: 7];
    endfunction

    // Caller sits at a negedge; the strobe is sampled at the next posedge.
    task automatic send(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_done: no done pulse within %0d cycles", n);
        end
    endtask

    initial begin
        int n;
        int done_cnt;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d0", 64'(dig(0)), 64'h40);
        chk("rst_hi", 64'(hex[55:7]), 64'({7{7'h7F}}));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single conversion
        send(32'd12345);
        wait_done(n);
        chk("lat_12345", 64'(n), 64'd33);
        chk("d0_12345", 64'(dig(0)), 64'h12);
        chk("d1_12345", 64'(dig(1)), 64'h19);
        chk("d2_12345", 64'(dig(2)), 64'h30);
        chk("d3_12345", 64'(dig(3)), 64'h24);
        chk("d4_12345", 64'(dig(4)), 64'h79);
        chk("hi_12345", 64'(hex[55:35]), 64'({3{7'h7F}}));
        @(negedge clk);
        chk("done_pulse_once", 64'(done), 64'd0);

        // Overflow and back to zero
        send(32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("d0_max", 64'(dig(0)), 64'h12);
        chk("d1_max", 64'(dig(1)), 64'h10);
        chk("d4_max", 64'(dig(4)), 64'h02);
        chk("d7_max", 64'(dig(7)), 64'h10);
        send(32'd0);
        wait_done(n);
        chk("d0_zero", 64'(dig(0)), 64'h40);
        chk("hi_zero", 64'(hex[55:7]), 64'({7{7'h7F}}));
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Pending overwrite: 7 at edge 0, 8 at edge 5, 9 at edge 10
        send(32'd7);
        repeat (4) @(negedge clk);
        send(32'd8);
        repeat (4) @(negedge clk);
        send(32'd9);
        wait_done(n);
        chk("lat_pend_a", 64'(n), 64'd23);
        chk("d0_pend_a", 64'(dig(0)), 64'h78);
        chk("busy_restart", 64'(busy), 64'd1);
        @(negedge clk);
        wait_done(n);
        chk("lat_pend_c", 64'(n), 64'd32);
        chk("d0_pend_c", 64'(dig(0)), 64'h10);
        chk("d1_pend_c", 64'(dig(1)), 64'h7F);

        // Coincident load at the DONE edge beats the parked value
        send(32'd100);
        repeat (2) @(negedge clk);
        send(32'd5);
        repeat (29) @(negedge clk);
        send(32'd42);
        chk("coin_done", 64'(done), 64'd1);
        chk("d2_100", 64'(dig(2)), 64'h79);
        chk("d0_100", 64'(dig(0)), 64'h40);
        @(negedge clk);
        wait_done(n);
        chk("d0_42", 64'(dig(0)), 64'h24);
        chk("d1_42", 64'(dig(1)), 64'h19);
        chk("d2_42", 64'(dig(2)), 64'h7F);
        chk("pend_dropped", 64'(busy), 64'd0);

        // Reset in the middle of a conversion
        send(32'd999);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_d0", 64'(dig(0)), 64'h40);
        chk("mid_rst_hi", 64'(hex[55:7]), 64'({7{7'h7F}}));
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("no_done_after_rst", 64'(done_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
